// File: rtl/shiftreg_chain_driver_if.sv
// Host-side bundle for the shift-register chain driver: frame request, bit order,
// clock enable and the serial/handshake outputs.
interface shiftreg_chain_driver_if #(
  parameter int unsigned TOTAL = 16
);
  logic             en;
  logic [TOTAL-1:0] data;
  logic             start;
  logic             lsb_first;
  logic             sda;
  logic             sck;
  logic             latch;
  logic             busy;
  logic             done;

  modport master (
    output en, data, start, lsb_first,
    input  sda, sck, latch, busy, done
  );

  modport slave (
    input  en, data, start, lsb_first,
    output sda, sck, latch, busy, done
  );
endinterface

// File: rtl/shiftreg_chain_driver.sv
// Serial driver for a daisy-chain of 74HC164/74HC595-style shift registers:
// shifts a captured parallel frame out on sda/sck and pulses the storage latch.
module shiftreg_chain_driver #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_DEV = 2,
  parameter int unsigned CLK_DIV = 2
) (
  input logic                    clk,
  input logic                    nrst,
  shiftreg_chain_driver_if.slave bus
);

  localparam int unsigned TOTAL = WIDTH * NUM_DEV;
  localparam int unsigned BIT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(TOTAL - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [TOTAL-1:0] sr_q, sr_d;
  logic             lsb_q, lsb_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             sda_q, sda_d;
  logic             sck_q, sck_d;
  logic             latch_q, latch_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [TOTAL-1:0] sr_shift;
  logic             div_end;

  // State and output registers; en freezes everything except reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      lsb_q     <= 1'b0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      sda_q     <= 1'b0;
      sck_q     <= 1'b0;
      latch_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (bus.en) begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      lsb_q     <= lsb_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      sda_q     <= sda_d;
      sck_q     <= sck_d;
      latch_q   <= latch_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state and next-output logic; every half-period lasts CLK_DIV cycles.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    lsb_d     = lsb_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    sda_d     = sda_q;
    sck_d     = sck_q;
    latch_d   = latch_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    div_end  = (div_cnt_q == DIV_LAST);
    sr_shift = lsb_q ? (sr_q >> 1) : (sr_q << 1);

    case (state_q)
      IDLE: begin
        sda_d   = 1'b0;
        sck_d   = 1'b0;
        latch_d = 1'b0;
        busy_d  = 1'b0;
        if (bus.start) begin
          state_d   = SHIFT_LO;
          sr_d      = bus.data;
          lsb_d     = bus.lsb_first;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          sda_d     = bus.lsb_first ? bus.data[0] : bus.data[TOTAL-1];
          busy_d    = 1'b1;
        end
      end

      SHIFT_LO: begin
        if (div_end) begin
          div_cnt_d = '0;
          sck_d     = 1'b1;
          state_d   = SHIFT_HI;
        end else begin
          div_cnt_d = DIV_W'(div_cnt_q + 1'b1);
        end
      end

      SHIFT_HI: begin
        if (div_end) begin
          div_cnt_d = '0;
          sck_d     = 1'b0;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = LATCH;
            sda_d   = 1'b0;
            latch_d = 1'b1;
          end else begin
            // Next bit goes out on the falling sck edge so setup equals hold.
            state_d   = SHIFT_LO;
            sr_d      = sr_shift;
            bit_cnt_d = BIT_W'(bit_cnt_q + 1'b1);
            sda_d     = lsb_q ? sr_shift[0] : sr_shift[TOTAL-1];
          end
        end else begin
          div_cnt_d = DIV_W'(div_cnt_q + 1'b1);
        end
      end

      LATCH: begin
        if (div_end) begin
          div_cnt_d = '0;
          state_d   = IDLE;
          latch_d   = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else begin
          div_cnt_d = DIV_W'(div_cnt_q + 1'b1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.sda   = sda_q;
  assign bus.sck   = sck_q;
  assign bus.latch = latch_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_shiftreg_chain_driver.sv
// Bench for shiftreg_chain_driver: directed and randomized frames on a CLK_DIV=2
// instance and a CLK_DIV=1 instance, checked against a bit-order/timing model.
module tb_shiftreg_chain_driver;

  localparam int unsigned TOTAL = 16;

  logic        clk = 1'b0;
  logic        nrst;
  logic        en;
  logic        start;
  logic        lsb_first;
  logic        sel;
  logic [15:0] data;

  int n_checks = 0;
  int n_pass   = 0;

  shiftreg_chain_driver_if #(.TOTAL(TOTAL)) bus0 ();
  shiftreg_chain_driver_if #(.TOTAL(TOTAL)) bus1 ();

  assign bus0.en        = en;
  assign bus0.data      = data;
  assign bus0.start     = start & ~sel;
  assign bus0.lsb_first = lsb_first;
  assign bus1.en        = en;
  assign bus1.data      = data;
  assign bus1.start     = start & sel;
  assign bus1.lsb_first = lsb_first;

  logic sda, sck, latch, busy, done;
  assign sda   = sel ? bus1.sda   : bus0.sda;
  assign sck   = sel ? bus1.sck   : bus0.sck;
  assign latch = sel ? bus1.latch : bus0.latch;
  assign busy  = sel ? bus1.busy  : bus0.busy;
  assign done  = sel ? bus1.done  : bus0.done;

  shiftreg_chain_driver #(.WIDTH(8), .NUM_DEV(2), .CLK_DIV(2)) dut0 (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus0)
  );

  shiftreg_chain_driver #(.WIDTH(8), .NUM_DEV(2), .CLK_DIV(1)) dut1 (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus1)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Order in which the chain should see the bits, first-shifted bit in [15].
  function automatic logic [15:0] model_word(input logic [15:0] d, input logic lsb);
    logic [15:0] w;
    for (int i = 0; i < 16; i++) w[15-i] = lsb ? d[i] : d[15-i];
    return w;
  endfunction

  // Caller has start/data/lsb_first driven; the next edge is the accept edge.
  task automatic run_frame(input logic [15:0] d, input logic lsb, input int gate_bit,
                           input int gate_len, input int stop_bit, input bit noise);
    int          cd;
    int          n;
    int          nbits;
    int          busy_cnt;
    int          latch_cnt;
    int          last_rise;
    bit          ok_period;
    bit          ok_overlap;
    bit          ok_gate;
    bit          gated;
    logic        prev_sck;
    logic        held;
    logic [15:0] exp_word;
    logic [15:0] got;

    cd         = sel ? 1 : 2;
    exp_word   = model_word(d, lsb);
    got        = '0;
    nbits      = 0;
    busy_cnt   = 0;
    latch_cnt  = 0;
    last_rise  = 0;
    ok_period  = 1'b1;
    ok_overlap = 1'b1;
    ok_gate    = 1'b1;
    gated      = 1'b0;
    prev_sck   = 1'b0;
    held       = 1'b0;

    step();
    n = 1;
    check("accept_busy", 32'(busy), 32'd1);
    check("first_sda", 32'(sda), 32'(exp_word[15]));
    if (!noise) start = 1'b0;

    while (!done && n < 2000) begin
      if (sck && !prev_sck) begin
        if (nbits > 0 && gate_len == 0 && (n - last_rise) != 2 * cd) ok_period = 1'b0;
        last_rise = n;
        if (nbits < 16) got[15-nbits] = sda;
        nbits++;
        if (stop_bit == nbits - 1) return;
      end
      prev_sck = sck;
      busy_cnt += int'(busy);
      latch_cnt += int'(latch);
      if (latch && (sck || nbits != 16)) ok_overlap = 1'b0;

      if (gate_len > 0 && !gated && nbits == gate_bit + 1 && sck) begin
        gated = 1'b1;
        held  = sda;
        en    = 1'b0;
        for (int g = 0; g < gate_len; g++) begin
          step();
          n++;
          if (!(sck === 1'b1 && sda === held && busy === 1'b1 && latch === 1'b0))
            ok_gate = 1'b0;
        end
        en = 1'b1;
      end

      if (noise) begin
        start     = ($urandom_range(0, 5) == 0);
        data      = 16'($urandom);
        lsb_first = 1'($urandom);
      end
      step();
      n++;
    end

    check("done_seen", 32'(done), 32'd1);
    check("latency", 32'(n), 32'(2 * cd * 16 + cd + 1 + gate_len));
    check("done_busy_low", 32'(busy), 32'd0);
    check("done_latch_low", 32'(latch), 32'd0);
    check("bit_count", 32'(nbits), 32'd16);
    check("bit_sequence", 32'(got), 32'(exp_word));
    check("busy_cycles", 32'(busy_cnt), 32'(2 * cd * 16 + cd));
    check("latch_width", 32'(latch_cnt), 32'(cd));
    check("latch_after_last_bit", 32'(ok_overlap), 32'd1);
    if (gate_len == 0) check("sck_period", 32'(ok_period), 32'd1);
    else check("en_hold", 32'(ok_gate), 32'd1);
  endtask

  initial begin
    logic [15:0] d;
    logic        l;
    bit          quiet;

    nrst      = 1'b0;
    en        = 1'b1;
    start     = 1'b1;
    lsb_first = 1'b0;
    sel       = 1'b0;
    data      = 16'h0000;

    // Reset with start held high
    step();
    step();
    check("rst_sda", 32'(sda), 32'd0);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_latch", 32'(latch), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    nrst  = 1'b1;
    start = 1'b0;
    repeat (3) step();
    check("idle_after_rst_busy", 32'(busy), 32'd0);
    check("idle_after_rst_sck", 32'(sck), 32'd0);

    // start with en low must not be accepted
    en    = 1'b0;
    start = 1'b1;
    repeat (3) step();
    check("start_en_low", 32'(busy), 32'd0);
    start = 1'b0;
    en    = 1'b1;
    step();
    check("start_en_low_after", 32'(busy), 32'd0);

    // MSB frame, then LSB frame and 16'h0001 back-to-back from the done cycles
    data = 16'hA5C3; lsb_first = 1'b0; start = 1'b1;
    run_frame(16'hA5C3, 1'b0, -1, 0, -1, 1'b0);
    data = 16'hA5C3; lsb_first = 1'b1; start = 1'b1;
    run_frame(16'hA5C3, 1'b1, -1, 0, -1, 1'b1);
    data = 16'h0001; lsb_first = 1'b0; start = 1'b1;
    run_frame(16'h0001, 1'b0, -1, 0, -1, 1'b1);
    start = 1'b0;
    repeat (3) step();
    check("idle_between", 32'(busy), 32'd0);

    // Randomized frames with random idle gaps and mid-frame start noise
    for (int f = 0; f < 6; f++) begin
      d = 16'($urandom);
      l = 1'($urandom);
      data = d; lsb_first = l; start = 1'b1;
      run_frame(d, l, -1, 0, -1, 1'b1);
      start = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end

    // en dropped for 5 cycles during bit 7's high half
    d = 16'($urandom);
    data = d; lsb_first = 1'b0; start = 1'b1;
    run_frame(d, 1'b0, 7, 5, -1, 1'b0);
    start = 1'b0;
    step();

    // Reset in the middle of bit 9 aborts without a latch pulse
    d = 16'($urandom);
    data = d; lsb_first = 1'b1; start = 1'b1;
    run_frame(d, 1'b1, -1, 0, 9, 1'b0);
    start = 1'b0;
    nrst  = 1'b0;
    step();
    check("midrst_sda", 32'(sda), 32'd0);
    check("midrst_sck", 32'(sck), 32'd0);
    check("midrst_latch", 32'(latch), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    nrst  = 1'b1;
    quiet = 1'b1;
    repeat (12) begin
      step();
      if (latch || busy || sck || done) quiet = 1'b0;
    end
    check("midrst_quiet", 32'(quiet), 32'd1);

    // CLK_DIV=1 instance, all-ones frame
    sel  = 1'b1;
    data = 16'hFFFF; lsb_first = 1'b0; start = 1'b1;
    run_frame(16'hFFFF, 1'b0, -1, 0, -1, 1'b0);
    start = 1'b0;
    step();
    check("div1_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
